ifid_skid_stage: RTL and testbench

//  Parametrised IF/ID pipeline stage with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/ifid_pkg.sv | 27 ++
 rtl/ifid_slot.sv | 41 ++++
 rtl/ifid_skid_stage.sv | 173 +++++++++++++++++
 tb/tb_ifid_skid_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared types and instruction field positions for the IF/ID skid stage.
package ifid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } ifid_state_t;

    localparam logic [15:0] NOP_INSTR_DEF = 16'hF000;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 8;
    localparam int RS_HI    = 7;
    localparam int RS_LO    = 4;
    localparam int RT_HI    = 3;
    localparam int RT_LO    = 0;
    localparam int BC_HI    = 10;
    localparam int BC_LO    = 8;
    localparam int IMM8_HI  = 7;
    localparam int IMM8_LO  = 0;
    localparam int TGT12_HI = 11;
    localparam int TGT12_LO = 0;

endpackage

// File: rtl/ifid_slot.sv
// One pipeline entry: valid flag plus {instr, pc}; clear wins over load and restores the NOP.
module ifid_slot #(
    parameter int unsigned PC_W      = 16,
    parameter logic [15:0] NOP_INSTR = 16'hF000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [15:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    output logic [15:0]     o_instr,
    output logic [PC_W-1:0] o_pc
);

    logic            r_valid;
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID stage: valid/ready handshake, optional skid slot, pre-sliced fields, stall/flush counters.
module ifid_skid_stage
    import ifid_pkg::*;
#(
    parameter int unsigned PC_W      = 16,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter bit          SKID_EN   = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [15:0]      i_instruction_in,
    input  logic [PC_W-1:0]  i_pc_in,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [15:0]      o_instruction_out,
    output logic [PC_W-1:0]  o_pc_out,
    output logic [3:0]       o_cntrl_input,
    output logic [3:0]       o_reg_rd,
    output logic [3:0]       o_reg_rs,
    output logic [3:0]       o_reg_rt,
    output logic [2:0]       o_branch_cond,
    output logic [3:0]       o_arith_imm,
    output logic [7:0]       o_load_save_imm,
    output logic [11:0]      o_call_target,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    ifid_state_t      r_state;
    ifid_state_t      w_state_d;
    logic             w_accept;
    logic             w_drain;
    logic             w_head_load;
    logic             w_head_clr;
    logic             w_skid_load;
    logic             w_skid_clr;
    logic             w_head_valid;
    logic [15:0]      w_head_instr;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_skid_valid;
    logic [15:0]      w_skid_instr;
    logic [PC_W-1:0]  w_skid_pc;
    logic [15:0]      w_head_instr_in;
    logic [PC_W-1:0]  w_head_pc_in;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign o_in_ready  = SKID_EN ? (r_state != FULL) : (!w_head_valid || i_out_ready);
    assign o_out_valid = w_head_valid;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_drain     = o_out_valid && i_out_ready;

    // Flush overrides everything, including an accept offered in the same cycle.
    always_comb begin
        w_state_d   = r_state;
        w_head_load = 1'b0;
        w_head_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        if (i_flush) begin
            w_state_d  = EMPTY;
            w_head_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_head_load = 1'b1;
                        w_state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (w_accept && w_drain) begin
                        w_head_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_d   = FULL;
                    end else if (w_drain) begin
                        w_head_clr = 1'b1;
                        w_state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_head_load = 1'b1;
                        w_skid_clr  = 1'b1;
                        w_state_d   = BUSY;
                    end
                end
                default: w_state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= EMPTY;
        else       r_state <= w_state_d;
    end

    // The skid entry is always older than the input, so it refills the head first.
    assign w_head_instr_in = (r_state == FULL) ? w_skid_instr : i_instruction_in;
    assign w_head_pc_in    = (r_state == FULL) ? w_skid_pc    : i_pc_in;

    ifid_slot #(.PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_head (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_head_load),
        .i_clear (w_head_clr),
        .i_instr (w_head_instr_in),
        .i_pc    (w_head_pc_in),
        .o_valid (w_head_valid),
        .o_instr (w_head_instr),
        .o_pc    (w_head_pc)
    );

    generate
        if (SKID_EN) begin : g_skid
            ifid_slot #(.PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_skid (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clr),
                .i_instr (i_instruction_in),
                .i_pc    (i_pc_in),
                .o_valid (w_skid_valid),
                .o_instr (w_skid_instr),
                .o_pc    (w_skid_pc)
            );
        end else begin : g_no_skid
            logic w_unused_skid;
            assign w_skid_valid  = 1'b0;
            assign w_skid_instr  = NOP_INSTR;
            assign w_skid_pc     = '0;
            assign w_unused_skid = w_skid_load ^ w_skid_clr ^ w_skid_valid;
        end
    endgenerate

    assign o_instruction_out = w_head_valid ? w_head_instr : NOP_INSTR;
    assign o_pc_out          = w_head_valid ? w_head_pc    : '0;

    assign o_cntrl_input   = o_instruction_out[OPC_HI:OPC_LO];
    assign o_reg_rd        = o_instruction_out[RD_HI:RD_LO];
    assign o_reg_rs        = o_instruction_out[RS_HI:RS_LO];
    assign o_reg_rt        = o_instruction_out[RT_HI:RT_LO];
    assign o_branch_cond   = o_instruction_out[BC_HI:BC_LO];
    assign o_arith_imm     = o_instruction_out[RT_HI:RT_LO];
    assign o_load_save_imm = o_instruction_out[IMM8_HI:IMM8_LO];
    assign o_call_target   = o_instruction_out[TGT12_HI:TGT12_LO];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_out_valid && !i_out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (i_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Bench for ifid_skid_stage: three instances (skid/16-bit cnt, skid/2-bit cnt, no skid) vs queue models.
module tb_ifid_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic        flush;
    logic        out_ready;
    logic        cnt_clr;

    logic a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [15:0] a_instr, a_pc, a_stall, a_flush, b_instr, b_pc, c_instr, c_pc, c_stall, c_flush;
    logic [1:0]  b_stall, b_flush;
    logic [3:0]  a_opc, a_rd, a_rs, a_rt, a_aimm, b_opc, b_rd, b_rs, b_rt, b_aimm;
    logic [3:0]  c_opc, c_rd, c_rs, c_rt, c_aimm;
    logic [2:0]  a_bc, b_bc, c_bc;
    logic [7:0]  a_ls, b_ls, c_ls;
    logic [11:0] a_tgt, b_tgt, c_tgt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: an ordered queue of {instr, pc}; capacity 2 with skid, 1 pass-through without.
    logic [31:0] q1[$];
    logic [31:0] q0[$];
    int unsigned st_a, st_b, st_c, fl_a, fl_b;

    always #5 clk = ~clk;

    ifid_skid_stage #(.PC_W(16), .SKID_EN(1'b1), .CNT_W(16)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(a_in_ready),
        .i_instruction_in(instr_in), .i_pc_in(pc_in), .i_flush(flush),
        .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_instruction_out(a_instr),
        .o_pc_out(a_pc), .o_cntrl_input(a_opc), .o_reg_rd(a_rd), .o_reg_rs(a_rs),
        .o_reg_rt(a_rt), .o_branch_cond(a_bc), .o_arith_imm(a_aimm), .o_load_save_imm(a_ls),
        .o_call_target(a_tgt), .i_cnt_clr(cnt_clr), .o_stall_cnt(a_stall), .o_flush_cnt(a_flush)
    );

    ifid_skid_stage #(.PC_W(16), .SKID_EN(1'b1), .CNT_W(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(b_in_ready),
        .i_instruction_in(instr_in), .i_pc_in(pc_in), .i_flush(flush),
        .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_instruction_out(b_instr),
        .o_pc_out(b_pc), .o_cntrl_input(b_opc), .o_reg_rd(b_rd), .o_reg_rs(b_rs),
        .o_reg_rt(b_rt), .o_branch_cond(b_bc), .o_arith_imm(b_aimm), .o_load_save_imm(b_ls),
        .o_call_target(b_tgt), .i_cnt_clr(cnt_clr), .o_stall_cnt(b_stall), .o_flush_cnt(b_flush)
    );

    ifid_skid_stage #(.PC_W(16), .SKID_EN(1'b0), .CNT_W(16)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(c_in_ready),
        .i_instruction_in(instr_in), .i_pc_in(pc_in), .i_flush(flush),
        .o_out_valid(c_out_valid), .i_out_ready(out_ready), .o_instruction_out(c_instr),
        .o_pc_out(c_pc), .o_cntrl_input(c_opc), .o_reg_rd(c_rd), .o_reg_rs(c_rs),
        .o_reg_rt(c_rt), .o_branch_cond(c_bc), .o_arith_imm(c_aimm), .o_load_save_imm(c_ls),
        .o_call_target(c_tgt), .i_cnt_clr(cnt_clr), .o_stall_cnt(c_stall), .o_flush_cnt(c_flush)
    );

    task automatic model_reset();
        q1.delete();
        q0.delete();
        st_a = 0; st_b = 0; st_c = 0; fl_a = 0; fl_b = 0;
    endtask

    // Advance one rising edge, applying the handshake rules to the reference queues.
    task automatic tick();
        bit acc1, drn1, acc0, drn0;
        @(posedge clk);
        acc1 = in_valid && (q1.size() < 2);
        drn1 = (q1.size() > 0) && out_ready;
        acc0 = in_valid && ((q0.size() == 0) || out_ready);
        drn0 = (q0.size() > 0) && out_ready;
        if (cnt_clr) begin
            st_a = 0; st_b = 0; st_c = 0; fl_a = 0; fl_b = 0;
        end else begin
            if (q1.size() > 0 && !out_ready) begin
                if (st_a < 65535) st_a++;
                if (st_b < 3) st_b++;
            end
            if (q0.size() > 0 && !out_ready && st_c < 65535) st_c++;
            if (flush) begin
                if (fl_a < 65535) fl_a++;
                if (fl_b < 3) fl_b++;
            end
        end
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (drn1) void'(q1.pop_front());
            if (acc1) q1.push_back({instr_in, pc_in});
            if (drn0) void'(q0.pop_front());
            if (acc0) q0.push_back({instr_in, pc_in});
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; instr_in = 16'h0; pc_in = 16'h0;
        flush = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12 rst = 1'b0;
        model_reset();
        tick();
        n_checks++; if (a_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_instr !== 16'hF000) begin n_errors++; $display("FAIL rst_instr: got %h want f000", a_instr); end
        n_checks++; if (a_pc !== 16'h0) begin n_errors++; $display("FAIL rst_pc: got %h want 0", a_pc); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
        // Fill to FULL, then hit reset between clock edges.
        out_ready = 1'b0;
        in_valid = 1'b1; instr_in = 16'h1AAA; pc_in = 16'h8;  tick();
        instr_in = 16'h1BBB; pc_in = 16'hA; tick();
        in_valid = 1'b0;
        n_checks++; if (a_in_ready !== 1'b0) begin n_errors++; $display("FAIL pre_rst_full: got in_ready=%b want 0", a_in_ready); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_errors++; $display("FAIL async_rst_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_instr !== 16'hF000) begin n_errors++; $display("FAIL async_rst_instr: got %h want f000", a_instr); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_errors++; $display("FAIL async_rst_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_stall !== 16'h0) begin n_errors++; $display("FAIL async_rst_stall: got %0d want 0", a_stall); end
        #1 rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
    endtask

    task automatic test_stream();
        logic [15:0] stream [3];
        stream = '{16'h1123, 16'h2456, 16'h3789};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; instr_in = stream[k]; pc_in = 16'(2 * k);
            if (k == 0) begin
                #1;
                n_checks++; if (a_out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_lag: got valid=%b want 0", a_out_valid); end
            end
            tick();
            n_checks++; if (a_out_valid !== 1'b1 || a_instr !== stream[k] || a_pc !== 16'(2 * k)) begin
                n_errors++; $display("FAIL stream_out%0d: got %b/%h/%h want 1/%h/%h", k, a_out_valid, a_instr, a_pc, stream[k], 16'(2 * k));
            end
            n_checks++; if (c_instr !== stream[k]) begin n_errors++; $display("FAIL stream_noskid%0d: got %h want %h", k, c_instr, stream[k]); end
            if (k == 0) begin
                n_checks++; if ({a_opc, a_rd, a_rs, a_rt} !== 16'h1123) begin
                    n_errors++; $display("FAIL stream_fields: got opc=%h rd=%h rs=%h rt=%h want 1 1 2 3", a_opc, a_rd, a_rs, a_rt);
                end
                n_checks++; if (a_bc !== 3'd1 || a_aimm !== 4'd3 || a_ls !== 8'h23 || a_tgt !== 12'h123) begin
                    n_errors++; $display("FAIL stream_imm: got bc=%h ai=%h ls=%h tgt=%h want 1 3 23 123", a_bc, a_aimm, a_ls, a_tgt);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (a_out_valid !== 1'b0 || a_instr !== 16'hF000) begin
            n_errors++; $display("FAIL stream_empty: got %b/%h want 0/f000", a_out_valid, a_instr);
        end
    endtask

    task automatic test_stall();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; instr_in = 16'h1123; pc_in = 16'h0; tick();
        instr_in = 16'h2456; pc_in = 16'h2; tick();
        n_checks++; if (a_in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_full: got in_ready=%b want 0", a_in_ready); end
        n_checks++; if (c_in_ready !== 1'b0) begin n_errors++; $display("FAIL noskid_block: got in_ready=%b want 0", c_in_ready); end
        instr_in = 16'h3789; pc_in = 16'h4; tick(); tick();
        n_checks++; if (a_instr !== 16'h1123 || a_pc !== 16'h0) begin n_errors++; $display("FAIL stall_hold: got %h/%h want 1123/0", a_instr, a_pc); end
        n_checks++; if (a_stall !== 16'd3) begin n_errors++; $display("FAIL stall_cnt: got %0d want 3", a_stall); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (a_instr !== 16'h1123) begin n_errors++; $display("FAIL stall_release0: got %h want 1123", a_instr); end
        tick();
        n_checks++; if (a_instr !== 16'h2456 || a_pc !== 16'h2) begin n_errors++; $display("FAIL stall_release1: got %h/%h want 2456/2", a_instr, a_pc); end
        tick();
        n_checks++; if (a_out_valid !== 1'b0 || a_stall !== 16'd3) begin
            n_errors++; $display("FAIL stall_drained: got valid=%b cnt=%0d want 0/3", a_out_valid, a_stall);
        end
    endtask

    task automatic test_flush();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; instr_in = 16'h1111; pc_in = 16'h20; tick();
        instr_in = 16'h2222; pc_in = 16'h22; tick();
        instr_in = 16'h4ABC; pc_in = 16'h24; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b0 || a_instr !== 16'hF000) begin
            n_errors++; $display("FAIL flush_full: got %b/%h want 0/f000", a_out_valid, a_instr);
        end
        n_checks++; if (a_flush !== 16'd1) begin n_errors++; $display("FAIL flush_cnt: got %0d want 1", a_flush); end
        // Flush while empty: in_ready is high but the offered input must still be dropped.
        in_valid = 1'b1; flush = 1'b1; #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_ready: got %b want 1", a_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (a_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_drop: got a=%b c=%b want 0/0", a_out_valid, c_out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (a_out_valid !== 1'b0 || a_instr === 16'h4ABC) begin
                n_errors++; $display("FAIL flush_ghost%0d: got %b/%h want 0/f000", k, a_out_valid, a_instr);
            end
        end
        n_checks++; if (a_flush !== 16'd2) begin n_errors++; $display("FAIL flush_cnt2: got %0d want 2", a_flush); end
    endtask

    task automatic test_sat();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; instr_in = 16'h7777; pc_in = 16'h40; tick();
        in_valid = 1'b0;
        repeat (6) tick();
        n_checks++; if (b_stall !== 2'd3) begin n_errors++; $display("FAIL sat_stick: got %0d want 3", b_stall); end
        n_checks++; if (a_stall !== 16'd6) begin n_errors++; $display("FAIL sat_wide: got %0d want 6", a_stall); end
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        n_checks++; if (b_stall !== 2'd0 || a_stall !== 16'd0) begin
            n_errors++; $display("FAIL sat_clr: got b=%0d a=%0d want 0/0", b_stall, a_stall);
        end
        tick();
        n_checks++; if (b_stall !== 2'd1) begin n_errors++; $display("FAIL sat_resume: got %0d want 1", b_stall); end
        out_ready = 1'b1; tick();
        n_checks++; if (b_out_valid !== 1'b0) begin n_errors++; $display("FAIL sat_drain: got %b want 0", b_out_valid); end
    endtask

    task automatic test_noskid();
        out_ready = 1'b0;
        in_valid = 1'b1; instr_in = 16'h5555; pc_in = 16'h30; tick();
        instr_in = 16'h6666; pc_in = 16'h32; #1;
        n_checks++; if (c_in_ready !== 1'b0 || c_instr !== 16'h5555) begin
            n_errors++; $display("FAIL noskid_stall: got ready=%b instr=%h want 0/5555", c_in_ready, c_instr);
        end
        out_ready = 1'b1; #1;
        n_checks++; if (c_in_ready !== 1'b1) begin n_errors++; $display("FAIL noskid_comb_ready: got %b want 1", c_in_ready); end
        tick();
        n_checks++; if (c_out_valid !== 1'b1 || c_instr !== 16'h6666 || c_pc !== 16'h32) begin
            n_errors++; $display("FAIL noskid_passthru: got %b/%h/%h want 1/6666/32", c_out_valid, c_instr, c_pc);
        end
        in_valid = 1'b0; tick();
        n_checks++; if (c_out_valid !== 1'b0) begin n_errors++; $display("FAIL noskid_empty: got %b want 0", c_out_valid); end
    endtask

    task automatic test_random();
        logic [15:0] ei1, ep1, ei0, ep0;
        logic [42:0] ef;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 4) != 0;
            instr_in  = 16'($urandom);
            pc_in     = 16'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 16) == 0;
            cnt_clr   = ($urandom % 32) == 0;
            #1;
            ei1 = (q1.size() > 0) ? q1[0][31:16] : 16'hF000;
            ep1 = (q1.size() > 0) ? q1[0][15:0] : 16'h0;
            ei0 = (q0.size() > 0) ? q0[0][31:16] : 16'hF000;
            ep0 = (q0.size() > 0) ? q0[0][15:0] : 16'h0;
            ef = {4'(ei1 >> 12), 4'(ei1 >> 8), 4'(ei1 >> 4), 4'(ei1), 3'(ei1 >> 8), 4'(ei1),
                  8'(ei1), 12'(ei1)};
            n_checks++; if (a_in_ready !== (q1.size() < 2)) begin n_errors++; $display("FAIL rnd_a_ready@%0d: got %b want %b", n, a_in_ready, q1.size() < 2); end
            n_checks++; if (a_out_valid !== (q1.size() > 0) || a_instr !== ei1 || a_pc !== ep1) begin
                n_errors++; $display("FAIL rnd_a_head@%0d: got %b/%h/%h want %b/%h/%h", n, a_out_valid, a_instr, a_pc, q1.size() > 0, ei1, ep1);
            end
            n_checks++; if ({a_opc, a_rd, a_rs, a_rt, a_bc, a_aimm, a_ls, a_tgt} !== ef) begin
                n_errors++; $display("FAIL rnd_a_fields@%0d: got %h want %h", n, {a_opc, a_rd, a_rs, a_rt, a_bc, a_aimm, a_ls, a_tgt}, ef);
            end
            n_checks++; if (a_stall !== 16'(st_a) || a_flush !== 16'(fl_a)) begin
                n_errors++; $display("FAIL rnd_a_cnt@%0d: got %0d/%0d want %0d/%0d", n, a_stall, a_flush, st_a, fl_a);
            end
            n_checks++; if (b_instr !== ei1 || b_stall !== 2'(st_b) || b_flush !== 2'(fl_b)) begin
                n_errors++; $display("FAIL rnd_b@%0d: got %h/%0d/%0d want %h/%0d/%0d", n, b_instr, b_stall, b_flush, ei1, st_b, fl_b);
            end
            n_checks++; if (c_in_ready !== (q0.size() == 0 || out_ready)) begin
                n_errors++; $display("FAIL rnd_c_ready@%0d: got %b want %b", n, c_in_ready, q0.size() == 0 || out_ready);
            end
            n_checks++; if (c_out_valid !== (q0.size() > 0) || c_instr !== ei0 || c_pc !== ep0) begin
                n_errors++; $display("FAIL rnd_c_head@%0d: got %b/%h/%h want %b/%h/%h", n, c_out_valid, c_instr, c_pc, q0.size() > 0, ei0, ep0);
            end
            n_checks++; if (c_stall !== 16'(st_c)) begin n_errors++; $display("FAIL rnd_c_cnt@%0d: got %0d want %0d", n, c_stall, st_c); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_sat();
        test_noskid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
